// File: rtl/psum_buf_pkg.sv
// Shared constants and FSM encoding for the partial-sum buffer.
// The latencies are fixed by the adder tree that the buffer feeds and drains.
package psum_buf_pkg;

  localparam int RD_LAT         = 2;
  localparam int WR_LAT         = 3;
  localparam int DATA_WIDTH_DEF = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/psum_buf_mem.sv
// Psum storage: one combinational read port and one synchronous write port.
// Neither port is reset; first-pass reads are masked upstream.
module psum_mem
  import psum_buf_pkg::*;
#(
  parameter int  data_width = DATA_WIDTH_DEF,
  parameter int  depth      = 64,
  localparam int aw         = $clog2(depth)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [aw-1:0]                wr_addr,
  input  logic signed [data_width-1:0] wr_data,
  input  logic [aw-1:0]                rd_addr,
  output logic signed [data_width-1:0] rd_data
);

  logic signed [data_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A read and a write to the same entry on one edge returns the old value.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/psum_buf.sv
// Partial-sum buffer between adder-tree passes: replays the previous pass's
// psums as fifo_data, stores the new ones, and emits the last pass on out_data.
module psum_buf
  import psum_buf_pkg::*;
#(
  parameter int  data_width = DATA_WIDTH_DEF,
  parameter int  depth      = 64,
  localparam int aw         = $clog2(depth)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         start,
  input  logic [aw:0]                  cfg_len,
  input  logic [7:0]                   cfg_passes,
  input  logic                         in_valid,
  input  logic signed [data_width-1:0] psum_in,
  output logic signed [data_width-1:0] fifo_data,
  output logic                         out_valid,
  output logic signed [data_width-1:0] out_data,
  output logic                         busy,
  output logic                         done
);

  localparam logic [aw:0]   LEN_ONE = 1;
  localparam logic [aw-1:0] PTR_ONE = 1;

  state_t                       state_reg, state_next;
  logic [WR_LAT:1]              v_reg;
  logic [aw:0]                  len_reg;
  logic [7:0]                   passes_reg;
  logic [aw-1:0]                rd_ptr_reg, wr_ptr_reg;
  logic [7:0]                   rd_pass_reg, wr_pass_reg;
  logic signed [data_width-1:0] fifo_data_reg, out_data_reg, rd_data;
  logic                         out_valid_reg, done_reg, done_next;
  logic                         v_in, start_ok;
  logic                         rd_en, wr_en, rd_wrap, wr_wrap, wr_final;
  logic                         last_rd, last_wr, mem_we;
  logic [aw:0]                  len_m1;
  logic [7:0]                   passes_m1;

  assign len_m1    = len_reg - LEN_ONE;
  assign passes_m1 = passes_reg - 8'd1;
  assign rd_en     = v_reg[RD_LAT-1];
  assign wr_en     = v_reg[WR_LAT];
  assign rd_wrap   = ({1'b0, rd_ptr_reg} == len_m1);
  assign wr_wrap   = ({1'b0, wr_ptr_reg} == len_m1);
  assign wr_final  = (wr_pass_reg >= passes_m1);
  assign last_rd   = rd_en && rd_wrap && (rd_pass_reg == passes_m1);
  assign last_wr   = wr_en && wr_wrap && wr_final;
  assign mem_we    = !stall && wr_en && !wr_final;

  always_comb begin
    state_next = state_reg;
    start_ok   = 1'b0;
    v_in       = 1'b0;
    done_next  = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Input offered alongside the job's final read would overrun the job.
        v_in = in_valid && !last_rd;
        if (last_rd) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_wr) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else if (!stall) begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg         <= '0;
      len_reg       <= '0;
      passes_reg    <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      rd_pass_reg   <= '0;
      wr_pass_reg   <= '0;
      fifo_data_reg <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else if (!stall) begin
      v_reg         <= {v_reg[WR_LAT-1:1], v_in};
      out_valid_reg <= 1'b0;
      done_reg      <= done_next;
      if (start_ok) begin
        len_reg     <= cfg_len;
        passes_reg  <= cfg_passes;
        rd_ptr_reg  <= '0;
        wr_ptr_reg  <= '0;
        rd_pass_reg <= '0;
        wr_pass_reg <= '0;
      end
      if (rd_en) begin
        // The first pass has no previous psum; stale memory is masked to zero.
        fifo_data_reg <= (rd_pass_reg == 8'd0) ? '0 : rd_data;
        rd_ptr_reg    <= rd_wrap ? '0 : rd_ptr_reg + PTR_ONE;
        if (rd_wrap) begin
          rd_pass_reg <= rd_pass_reg + 8'd1;
        end
      end
      if (wr_en) begin
        wr_ptr_reg <= wr_wrap ? '0 : wr_ptr_reg + PTR_ONE;
        if (wr_wrap) begin
          wr_pass_reg <= wr_pass_reg + 8'd1;
        end
        if (wr_final) begin
          out_data_reg  <= psum_in;
          out_valid_reg <= 1'b1;
        end
      end
    end
  end

  psum_mem #(
    .data_width(data_width),
    .depth     (depth)
  ) u_mem (
    .clk    (clk),
    .we     (mem_we),
    .wr_addr(wr_ptr_reg),
    .wr_data(psum_in),
    .rd_addr(rd_ptr_reg),
    .rd_data(rd_data)
  );

  assign fifo_data = fifo_data_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_psum_buf.sv
// Self-checking bench for psum_buf: the bench plays the adder tree and checks
// fifo_data / out_data against a per-job model built from the accumulation rules.
module tb_psum_buf;

  localparam int DW    = 25;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic                 clk        = 1'b0;
  logic                 rst_n      = 1'b0;
  logic                 stall      = 1'b0;
  logic                 start      = 1'b0;
  logic [AW:0]          cfg_len    = '0;
  logic [7:0]           cfg_passes = '0;
  logic                 in_valid   = 1'b0;
  logic signed [DW-1:0] psum_in    = '0;
  logic signed [DW-1:0] fifo_data, out_data;
  logic                 out_valid, busy, done;

  psum_buf #(.data_width(DW), .depth(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_passes(cfg_passes),
    .in_valid  (in_valid),
    .psum_in   (psum_in),
    .fifo_data (fifo_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Per-job expectations: addend per element, expected fifo_data, final psums.
  logic signed [DW-1:0] add_q[$];
  logic signed [DW-1:0] fifo_q[$];
  logic signed [DW-1:0] out_q[$];
  int total   = 0;
  int acc_cnt = 0;
  bit m_busy    = 1'b0;
  bit done_seen = 1'b0;

  // Adder-tree emulation: element index at 1, 2 and 3 non-stalled cycles old.
  bit                   e_v [1:3];
  int                   e_i [1:3];
  logic signed [DW-1:0] e_f [1:3];

  task automatic clear_env();
    for (int k = 1; k <= 3; k++) begin
      e_v[k] = 1'b0;
      e_i[k] = 0;
      e_f[k] = '0;
    end
  endtask

  task automatic build_job(input int len, input int passes, input int mode);
    logic signed [DW-1:0] mm [DEPTH];
    logic signed [DW-1:0] a, f, s;
    add_q.delete();
    fifo_q.delete();
    out_q.delete();
    for (int i = 0; i < len * passes; i++) begin
      int n, p;
      n = i % len;
      p = i / len;
      case (mode)
        1:       a = DW'(10 * (n + 1));
        2:       a = DW'(5);
        default: a = DW'($urandom);
      endcase
      f = (p == 0) ? '0 : mm[n];
      s = f + a;
      if (p < passes - 1) mm[n] = s;
      else out_q.push_back(s);
      add_q.push_back(a);
      fifo_q.push_back(f);
    end
    total   = len * passes;
    acc_cnt = 0;
  endtask

  // One clock cycle: drive inputs after a falling edge, observe after the next.
  task automatic tick(input bit iv, input bit st, input bit stt);
    bit                   acc, exp_done;
    logic signed [DW-1:0] p_fifo, p_out, exp_v;
    logic                 p_ov, p_done, p_busy;
    if (e_v[2]) begin
      n_cmp++;
      if (fifo_data !== fifo_q[e_i[2]]) begin
        n_err++;
        $display("FAIL fifo_data elem %0d: got %0d required %0d", e_i[2], fifo_data, fifo_q[e_i[2]]);
      end
      e_f[2] = fifo_data;
    end
    p_fifo = fifo_data; p_out = out_data; p_ov = out_valid; p_done = done; p_busy = busy;
    psum_in  = e_v[3] ? DW'(e_f[3] + add_q[e_i[3]]) : DW'($urandom);
    in_valid = iv;
    stall    = st;
    start    = stt;
    acc = iv && !st && m_busy && (acc_cnt < total);
    @(posedge clk);
    @(negedge clk);
    if (st) begin
      n_cmp++;
      if ({fifo_data, out_data, out_valid, done, busy} !== {p_fifo, p_out, p_ov, p_done, p_busy}) begin
        n_err++;
        $display("FAIL stall_freeze: got fifo=%0d out=%0d ov=%0b done=%0b busy=%0b required fifo=%0d out=%0d ov=%0b done=%0b busy=%0b",
                 fifo_data, out_data, out_valid, done, busy, p_fifo, p_out, p_ov, p_done, p_busy);
      end
    end else begin
      e_v[3] = e_v[2]; e_i[3] = e_i[2]; e_f[3] = e_f[2];
      e_v[2] = e_v[1]; e_i[2] = e_i[1];
      e_v[1] = acc;    e_i[1] = acc_cnt;
      if (acc) acc_cnt++;
      if (stt && !m_busy) m_busy = 1'b1;
      exp_done = 1'b0;
      if (out_valid) begin
        n_cmp++;
        if (out_q.size() == 0) begin
          n_err++;
          $display("FAIL out_valid_extra: got out_valid=1 out_data=%0d required out_valid=0", out_data);
        end else begin
          exp_v = out_q.pop_front();
          if (out_data !== exp_v) begin
            n_err++;
            $display("FAIL out_data: got %0d required %0d", out_data, exp_v);
          end
          if (out_q.size() == 0 && m_busy) begin
            exp_done = 1'b1;
            m_busy   = 1'b0;
          end
        end
      end
      n_cmp++;
      if (done !== exp_done) begin
        n_err++;
        $display("FAIL done: got %0b required %0b", done, exp_done);
      end
      n_cmp++;
      if (busy !== m_busy) begin
        n_err++;
        $display("FAIL busy: got %0b required %0b", busy, m_busy);
      end
      if (done) done_seen = 1'b1;
    end
  endtask

  task automatic run_job(input int len, input int passes, input int mode,
                         input int gap_pct, input int stall_mode, input bit poke);
    bit iv, st, stt;
    build_job(len, passes, mode);
    done_seen  = 1'b0;
    cfg_len    = (AW+1)'(len);
    cfg_passes = 8'(passes);
    tick(1'b0, 1'b0, 1'b1);
    // Configuration must have been latched; scramble it for the rest of the job.
    cfg_len    = (AW+1)'($urandom_range(4, DEPTH));
    cfg_passes = 8'($urandom_range(1, 255));
    for (int c = 0; c < 3000 && !done_seen; c++) begin
      iv  = ($urandom_range(99) >= gap_pct);
      st  = (stall_mode != 0 && c >= 6 && c <= 8) ||
            (stall_mode == 2 && $urandom_range(99) < 15);
      stt = poke && (c == 5);
      tick(iv, st, stt);
    end
    n_cmp++;
    if (!done_seen || out_q.size() != 0) begin
      n_err++;
      $display("FAIL job_end len=%0d passes=%0d: got done_seen=%0b left=%0d required done_seen=1 left=0",
               len, passes, done_seen, out_q.size());
    end
    $display("job len=%0d passes=%0d mode=%0d gap=%0d stall=%0d poke=%0b: compared=%0d mismatched=%0d",
             len, passes, mode, gap_pct, stall_mode, poke, n_cmp, n_err);
  endtask

  task automatic test_reset();
    clear_env();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({fifo_data, out_data, out_valid, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got fifo=%0d out=%0d ov=%0b busy=%0b done=%0b required all 0",
               fifo_data, out_data, out_valid, busy, done);
    end
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    $display("reset: compared=%0d mismatched=%0d", n_cmp, n_err);
  endtask

  task automatic test_single_pass();
    run_job(4, 1, 1, 0, 0, 1'b0);
  endtask

  task automatic test_accumulate();
    run_job(4, 3, 2, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job(4, 4, 0, 0, 0, 1'b0);
    run_job(DEPTH, 2, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) begin
      run_job($urandom_range(4, DEPTH), $urandom_range(1, 4), 0, 30, 0, 1'b0);
    end
  endtask

  task automatic test_stall();
    run_job(4, 2, 0, 0, 1, 1'b0);
    run_job(8, 3, 0, 20, 2, 1'b0);
  endtask

  task automatic test_start_busy();
    run_job(8, 2, 0, 10, 0, 1'b1);
  endtask

  task automatic test_idle_valid();
    logic signed [DW-1:0] f0;
    f0 = fifo_data;
    for (int c = 0; c < 8; c++) begin
      tick(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0 || fifo_data !== f0) begin
        n_err++;
        $display("FAIL idle_valid: got ov=%0b fifo=%0d required ov=0 fifo=%0d", out_valid, fifo_data, f0);
      end
    end
    run_job(4, 2, 0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_midjob();
    build_job(8, 2, 0);
    done_seen  = 1'b0;
    cfg_len    = (AW+1)'(8);
    cfg_passes = 8'd2;
    tick(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) tick(1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_data, out_data, out_valid, busy, done} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got fifo=%0d out=%0d ov=%0b busy=%0b done=%0b required all 0",
               fifo_data, out_data, out_valid, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: got done=%0b busy=%0b required 0 0", done, busy);
      end
    end
    rst_n  = 1'b1;
    m_busy = 1'b0;
    clear_env();
    out_q.delete();
    run_job(8, 2, 0, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_accumulate();
    test_back_to_back();
    test_random();
    test_stall();
    test_start_busy();
    test_idle_valid();
    test_reset_midjob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
